cosim_trace_serializer: RTL and testbench

- Parametrised successor to the two-lane cosim trace tap.
- Accepts NRET retirement lanes per cycle and filters out lanes with no event.
- Compacts the remaining lanes in lane order into a DEPTH-entry FIFO, stamping each record with cycle, hartid and a sequence number.
- Drains one record per cycle over a valid/ready interface to the cospike DPI bridge. Provides core backpressure, overflow detection and a drop counter.

---
 rtl/cosim_trace_serializer.sv | 219 +++++++++++++++++++++
 tb/tb_cosim_trace_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_trace_serializer.sv
// cosim_trace_serializer
// Collects up to NRET retirement lanes per cycle and drops lanes that carry no
// event. The remaining lanes are packed, in lane order, into a DEPTH-entry
// FIFO. Each record is stamped with cycle, hartid and a sequence number. The
// FIFO drains one record per cycle over a valid/ready interface
// (first-word-fall-through).
//
// If a cycle group does not fit in the free space at the start of the cycle,
// the whole group is dropped. The drop sets a sticky overflow flag and adds to
// a saturating drop counter.
//
// Ports:
//   clock, reset                 clock, synchronous active-low reset
//   cycle, hartid                stamps sampled at enqueue
//   trace_*                      per-lane retire buses, lane i at [i*W +: W]
//   out_valid/out_ready          drain handshake
//   out_*                        head record fields (0 while empty)
//   clear_overflow               clears overflow and drop_count
//   stall                        registered backpressure to the core
//   overflow, drop_count         drop reporting
//   occupancy                    entries currently held
module cosim_trace_serializer #(
  parameter int NRET  = 2,
  parameter int XLEN  = 64,
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16,
  parameter int AFULL = 2 * NRET,
  parameter int CNT_W = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [63:0]          cycle,
  input  logic [63:0]          hartid,
  input  logic [NRET-1:0]      trace_valid,
  input  logic [NRET*XLEN-1:0] trace_iaddr,
  input  logic [NRET*32-1:0]   trace_insn,
  input  logic [NRET-1:0]      trace_exception,
  input  logic [NRET-1:0]      trace_interrupt,
  input  logic [NRET*XLEN-1:0] trace_cause,
  input  logic [NRET-1:0]      trace_has_wdata,
  input  logic [NRET*XLEN-1:0] trace_wdata,
  input  logic [NRET*3-1:0]    trace_priv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_cycle,
  output logic [63:0]          out_hartid,
  output logic [SEQ_W-1:0]     out_seq,
  output logic                 out_insn_valid,
  output logic [XLEN-1:0]      out_iaddr,
  output logic [31:0]          out_insn,
  output logic                 out_exception,
  output logic                 out_interrupt,
  output logic [XLEN-1:0]      out_cause,
  output logic                 out_has_wdata,
  output logic [XLEN-1:0]      out_wdata,
  output logic [2:0]           out_priv,
  input  logic                 clear_overflow,
  output logic                 stall,
  output logic                 overflow,
  output logic [CNT_W-1:0]     drop_count,
  output logic [OCC_W-1:0]     occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW    = $clog2(NRET + 1);

  typedef struct packed {
    logic [63:0]      cycle;
    logic [63:0]      hartid;
    logic [SEQ_W-1:0] seq;
    logic             insn_valid;
    logic [XLEN-1:0]  iaddr;
    logic [31:0]      insn;
    logic             exc;
    logic             intr;
    logic [XLEN-1:0]  cause;
    logic             has_wdata;
    logic [XLEN-1:0]  wdata;
    logic [2:0]       priv;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             stall_q, stall_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [NRET-1:0]  qual_s;
  logic [KW-1:0]    offset_s [NRET];
  logic [KW-1:0]    k_s;
  rec_t             rec_s [NRET];
  logic [OCC_W-1:0] free_s, free_next_s, enq_cnt_s;
  logic             accept_s, deq_s;
  logic [CNT_W:0]   drop_sum_s;
  rec_t             head_s;

  // Qualify lanes; each lane's slot offset is the count of qualifying lanes below it.
  always_comb begin
    k_s = '0;
    for (int i = 0; i < NRET; i++) begin
      qual_s[i]   = trace_valid[i] | trace_exception[i] |
                    (trace_cause[i*XLEN +: XLEN] != '0);
      offset_s[i] = k_s;
      k_s         = k_s + KW'(qual_s[i]);
      rec_s[i].cycle      = cycle;
      rec_s[i].hartid     = hartid;
      rec_s[i].seq        = seq_q + SEQ_W'(k_s) - SEQ_W'(qual_s[i]);
      rec_s[i].insn_valid = trace_valid[i];
      rec_s[i].iaddr      = trace_iaddr[i*XLEN +: XLEN];
      rec_s[i].insn       = trace_insn[i*32 +: 32];
      rec_s[i].exc        = trace_exception[i];
      rec_s[i].intr       = trace_interrupt[i];
      rec_s[i].cause      = trace_cause[i*XLEN +: XLEN];
      rec_s[i].has_wdata  = trace_has_wdata[i];
      rec_s[i].wdata      = trace_wdata[i*XLEN +: XLEN];
      rec_s[i].priv       = trace_priv[i*3 +: 3];
    end
  end

  // Enqueue, dequeue, counters and stall next-state.
  always_comb begin
    // Free space is judged on the registered occupancy; a same-cycle dequeue
    // does not make room for this cycle's group.
    free_s      = OCC_W'(DEPTH) - occ_q;
    accept_s    = (int'(k_s) <= int'(free_s));
    deq_s       = (occ_q != '0) && out_ready;
    enq_cnt_s   = accept_s ? OCC_W'(k_s) : '0;
    occ_d       = occ_q + enq_cnt_s - OCC_W'(deq_s);
    free_next_s = OCC_W'(DEPTH) - occ_d;
    stall_d     = (int'(free_next_s) < AFULL);
    drop_sum_s  = {1'b0, drop_q} + (CNT_W+1)'(k_s);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    seq_d       = seq_q;
    ovf_d       = ovf_q;
    drop_d      = drop_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(k_s);
      seq_d    = seq_q + SEQ_W'(k_s);
      if (clear_overflow) begin
        ovf_d  = 1'b0;
        drop_d = '0;
      end else begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
      end
    end else begin
      ovf_d = 1'b1;
      if (clear_overflow) begin
        drop_d = CNT_W'(k_s);
      end else if (drop_sum_s[CNT_W]) begin
        drop_d = '1;
      end else begin
        drop_d = drop_sum_s[CNT_W-1:0];
      end
    end
    if (deq_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Control and status registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      seq_q    <= '0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      seq_q    <= seq_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Record storage: a whole accepted group lands in one edge.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NRET; i++) begin
      if (reset && accept_s && qual_s[i]) begin
        mem_q[wr_ptr_q + PTR_W'(offset_s[i])] <= rec_s[i];
      end
    end
  end

  // Head fields are forced to zero while empty so stale storage never shows.
  always_comb begin
    head_s = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
  end

  assign out_valid      = (occ_q != '0);
  assign out_cycle      = head_s.cycle;
  assign out_hartid     = head_s.hartid;
  assign out_seq        = head_s.seq;
  assign out_insn_valid = head_s.insn_valid;
  assign out_iaddr      = head_s.iaddr;
  assign out_insn       = head_s.insn;
  assign out_exception  = head_s.exc;
  assign out_interrupt  = head_s.intr;
  assign out_cause      = head_s.cause;
  assign out_has_wdata  = head_s.has_wdata;
  assign out_wdata      = head_s.wdata;
  assign out_priv       = head_s.priv;
  assign stall          = stall_q;
  assign overflow       = ovf_q;
  assign drop_count     = drop_q;
  assign occupancy      = occ_q;

endmodule

// File: tb/tb_cosim_trace_serializer.sv
module tb_cosim_trace_serializer;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [63:0]  cycle = 64'd0;
  logic [63:0]  hartid = 64'd0;
  logic [1:0]   trace_valid = 2'b00;
  logic [127:0] trace_iaddr = 128'd0;
  logic [63:0]  trace_insn = 64'd0;
  logic [1:0]   trace_exception = 2'b00;
  logic [1:0]   trace_interrupt = 2'b00;
  logic [127:0] trace_cause = 128'd0;
  logic [1:0]   trace_has_wdata = 2'b00;
  logic [127:0] trace_wdata = 128'd0;
  logic [5:0]   trace_priv = 6'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_cycle, out_hartid;
  logic [15:0]  out_seq;
  logic         out_insn_valid;
  logic [63:0]  out_iaddr;
  logic [31:0]  out_insn;
  logic         out_exception, out_interrupt;
  logic [63:0]  out_cause;
  logic         out_has_wdata;
  logic [63:0]  out_wdata;
  logic [2:0]   out_priv;
  logic         clear_overflow = 1'b0;
  logic         stall, overflow;
  logic [15:0]  drop_count;
  logic [4:0]   occupancy;

  int checks = 0;
  int errors = 0;

  cosim_trace_serializer dut (
    .clock(clock), .reset(reset), .cycle(cycle), .hartid(hartid),
    .trace_valid(trace_valid), .trace_iaddr(trace_iaddr), .trace_insn(trace_insn),
    .trace_exception(trace_exception), .trace_interrupt(trace_interrupt),
    .trace_cause(trace_cause), .trace_has_wdata(trace_has_wdata),
    .trace_wdata(trace_wdata), .trace_priv(trace_priv),
    .out_valid(out_valid), .out_ready(out_ready), .out_cycle(out_cycle),
    .out_hartid(out_hartid), .out_seq(out_seq), .out_insn_valid(out_insn_valid),
    .out_iaddr(out_iaddr), .out_insn(out_insn), .out_exception(out_exception),
    .out_interrupt(out_interrupt), .out_cause(out_cause),
    .out_has_wdata(out_has_wdata), .out_wdata(out_wdata), .out_priv(out_priv),
    .clear_overflow(clear_overflow), .stall(stall), .overflow(overflow),
    .drop_count(drop_count), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  valid;
    logic        ready;
    logic        clr;
    logic [4:0]  occ;
    logic        stl;
    logic        ovf;
    logic [15:0] drop;
    logic [15:0] seq;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_lanes();
    trace_valid = 2'b00;
    trace_exception = 2'b00;
    trace_interrupt = 2'b00;
    trace_cause = 128'd0;
    trace_has_wdata = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int n;
    logic [15:0] exp_seq;

    // valid, ready, clr, occ, stall, ovf, drop, head seq
    vecs[0]  = '{2'b11, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1]  = '{2'b11, 1'b0, 1'b0, 5'd4,  1'b0, 1'b0, 16'd0, 16'd0};
    vecs[2]  = '{2'b11, 1'b0, 1'b0, 5'd6,  1'b0, 1'b0, 16'd0, 16'd0};
    vecs[3]  = '{2'b11, 1'b0, 1'b0, 5'd8,  1'b0, 1'b0, 16'd0, 16'd0};
    vecs[4]  = '{2'b11, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[5]  = '{2'b11, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[6]  = '{2'b11, 1'b0, 1'b0, 5'd14, 1'b1, 1'b0, 16'd0, 16'd0};
    vecs[7]  = '{2'b11, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 16'd0, 16'd0};
    vecs[8]  = '{2'b11, 1'b0, 1'b0, 5'd16, 1'b1, 1'b1, 16'd2, 16'd0};
    vecs[9]  = '{2'b01, 1'b1, 1'b0, 5'd15, 1'b1, 1'b1, 16'd3, 16'd1};
    vecs[10] = '{2'b00, 1'b0, 1'b1, 5'd15, 1'b1, 1'b0, 16'd0, 16'd1};
    vecs[11] = '{2'b11, 1'b0, 1'b1, 5'd15, 1'b1, 1'b1, 16'd2, 16'd1};
    vecs[12] = '{2'b00, 1'b0, 1'b0, 5'd15, 1'b1, 1'b1, 16'd2, 16'd1};

    // Reset state.
    tick();
    tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_occ", {59'd0, occupancy}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_drop", {48'd0, drop_count}, 64'd0);
    chk("rst_iaddr", out_iaddr, 64'd0);
    reset = 1'b1;

    // Two lanes retire at cycle 100.
    cycle = 64'd100;
    hartid = 64'd3;
    out_ready = 1'b1;
    trace_valid = 2'b11;
    trace_iaddr = {64'h8000_0004, 64'h8000_0000};
    trace_insn = {32'h0000_0093, 32'h0000_0013};
    tick();
    idle_lanes();
    cycle = 64'd101;
    chk("pair_occ", {59'd0, occupancy}, 64'd2);
    chk("pair_seq0", {48'd0, out_seq}, 64'd0);
    chk("pair_iaddr0", out_iaddr, 64'h8000_0000);
    chk("pair_cyc0", out_cycle, 64'd100);
    chk("pair_hart0", out_hartid, 64'd3);
    chk("pair_insn0", {32'd0, out_insn}, 64'h13);
    tick();
    chk("pair_occ1", {59'd0, occupancy}, 64'd1);
    chk("pair_seq1", {48'd0, out_seq}, 64'd1);
    chk("pair_iaddr1", out_iaddr, 64'h8000_0004);
    chk("pair_cyc1", out_cycle, 64'd100);
    tick();
    chk("pair_empty", {63'd0, out_valid}, 64'd0);

    // Exception-only lane 1, then cause-only interrupt lane 1.
    do_reset();
    trace_exception = 2'b10;
    trace_cause = {64'd2, 64'd0};
    trace_iaddr = {64'h8000_0100, 64'h8000_0000};
    trace_priv = 6'b011_000;
    tick();
    idle_lanes();
    chk("exc_occ", {59'd0, occupancy}, 64'd1);
    chk("exc_seq", {48'd0, out_seq}, 64'd0);
    chk("exc_flag", {63'd0, out_exception}, 64'd1);
    chk("exc_insn_valid", {63'd0, out_insn_valid}, 64'd0);
    chk("exc_cause", out_cause, 64'd2);
    chk("exc_iaddr", out_iaddr, 64'h8000_0100);
    chk("exc_priv", {61'd0, out_priv}, 64'd3);
    tick();
    chk("exc_drained", {59'd0, occupancy}, 64'd0);
    trace_cause = {64'h8000_0000_0000_0007, 64'd0};
    trace_interrupt = 2'b10;
    tick();
    idle_lanes();
    chk("irq_occ", {59'd0, occupancy}, 64'd1);
    chk("irq_seq", {48'd0, out_seq}, 64'd1);
    chk("irq_flag", {63'd0, out_interrupt}, 64'd1);
    chk("irq_exc", {63'd0, out_exception}, 64'd0);
    chk("irq_cause", out_cause, 64'h8000_0000_0000_0007);
    tick();
    // A lane with only has_wdata set carries no event.
    trace_has_wdata = 2'b11;
    tick();
    idle_lanes();
    chk("noevent_occ", {59'd0, occupancy}, 64'd0);

    // Backpressure, overflow, full-with-dequeue and clear table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      trace_valid = vecs[i].valid;
      out_ready = vecs[i].ready;
      clear_overflow = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_occ", i), {59'd0, occupancy}, {59'd0, vecs[i].occ});
      chk($sformatf("vec%0d_stall", i), {63'd0, stall}, {63'd0, vecs[i].stl});
      chk($sformatf("vec%0d_ovf", i), {63'd0, overflow}, {63'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_drop", i), {48'd0, drop_count}, {48'd0, vecs[i].drop});
      chk($sformatf("vec%0d_seq", i), {48'd0, out_seq}, {48'd0, vecs[i].seq});
    end
    clear_overflow = 1'b0;

    // Seq stayed at 16 through the drops: the next accepted record gets 16.
    trace_valid = 2'b01;
    out_ready = 1'b1;
    tick();
    trace_valid = 2'b00;
    chk("refill_occ", {59'd0, occupancy}, 64'd15);
    exp_seq = 16'd2;
    n = 0;
    while (out_valid && n < 40) begin
      chk($sformatf("drain%0d_seq", n), {48'd0, out_seq}, {48'd0, exp_seq});
      exp_seq = exp_seq + 16'd1;
      n++;
      tick();
    end
    chk("drain_len", n, 64'd15);
    chk("drain_stall", {63'd0, stall}, 64'd0);

    // Reset with 9 entries held while lanes keep retiring.
    do_reset();
    out_ready = 1'b0;
    trace_valid = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    trace_valid = 2'b01;
    tick();
    chk("pre_rst_occ", {59'd0, occupancy}, 64'd9);
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    trace_valid = 2'b11;
    reset = 1'b0;
    tick();
    chk("mid_rst_occ", {59'd0, occupancy}, 64'd0);
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_stall", {63'd0, stall}, 64'd0);
    reset = 1'b1;
    trace_valid = 2'b01;
    trace_iaddr = {64'd0, 64'h8000_0200};
    tick();
    trace_valid = 2'b00;
    chk("post_rst_occ", {59'd0, occupancy}, 64'd1);
    chk("post_rst_seq", {48'd0, out_seq}, 64'd0);
    chk("post_rst_iaddr", out_iaddr, 64'h8000_0200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
